fb_arbiter: RTL and testbench

- Shares the single-port synchronous framebuffer SRAM between the VGA scanout reader and the drawing engine.
- Scanout has absolute priority so pixels are never late.
- Draw writes are posted into a small FIFO and drained in free cycles. Draw reads wait until all earlier writes have drained.
- Sits between the draw engine, the scanout pipeline and the framebuffer macro, inside the TinyTapeout top.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_arbiter_if.sv | 55 +++++
 rtl/fb_wq_fifo.sv | 71 +++++++
 rtl/fb_arbiter.sv | 159 +++++++++++++++
 tb/tb_fb_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and defaults for the framebuffer arbiter slice:
//               default bus widths, read-return tags and grant encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int c_addr_w_default = 15;
    localparam int c_data_w_default = 8;

    // Source of the SRAM read issued in the previous cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCAN = 2'd1,
        TAG_DRAW = 2'd2
    } rd_tag_e;

    // Owner of the SRAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_SCAN = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter_if
// Description : Bundle of the scanout, draw-engine, SRAM and status signals
//               around the framebuffer arbiter. The slave modport is the
//               arbiter's view; master is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_arbiter_if
    import fb_pkg::*;
#(
    parameter int ADDR_W   = c_addr_w_default,
    parameter int DATA_W   = c_data_w_default,
    parameter int WQ_DEPTH = 4
);
    localparam int c_lvl_w = $clog2(WQ_DEPTH + 1);

    // scanout reader
    logic               scan_req;
    logic [ADDR_W-1:0]  scan_addr;
    logic               scan_rvalid;
    logic [DATA_W-1:0]  scan_rdata;
    // drawing engine
    logic               dr_valid;
    logic               dr_ready;
    logic               dr_we;
    logic [ADDR_W-1:0]  dr_addr;
    logic [DATA_W-1:0]  dr_wdata;
    logic               dr_rvalid;
    logic [DATA_W-1:0]  dr_rdata;
    // framebuffer macro
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    // status
    logic [c_lvl_w-1:0] wq_level;
    logic               busy;
    logic               starve;

    modport slave (
        input  scan_req, scan_addr, dr_valid, dr_we, dr_addr, dr_wdata, mem_rdata,
        output scan_rvalid, scan_rdata, dr_ready, dr_rvalid, dr_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, wq_level, busy, starve
    );

    modport master (
        output scan_req, scan_addr, dr_valid, dr_we, dr_addr, dr_wdata, mem_rdata,
        input  scan_rvalid, scan_rdata, dr_ready, dr_rvalid, dr_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, wq_level, busy, starve
    );

endinterface
`default_nettype wire

// File: rtl/fb_wq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_wq_fifo
// Description : Small circular FIFO holding posted draw writes ({addr,data}).
//               Pointers wrap naturally because DEPTH is a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_wq_fifo
    import fb_pkg::*;
#(
    parameter int WIDTH = c_addr_w_default + c_data_w_default,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Entry storage; contents only matter where the count says they are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves the count alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Single-port framebuffer SRAM arbiter. Scanout reads win every
//               cycle; draw writes are posted into a FIFO and drained in idle
//               cycles; a draw read waits until the FIFO is empty so it sees
//               every earlier write.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = c_addr_w_default,
    parameter int DATA_W       = c_data_w_default,
    parameter int WQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    fb_arbiter_if.slave bus
);
    localparam int c_lvl_w   = $clog2(WQ_DEPTH + 1);
    localparam int c_stall_w = $clog2(STARVE_LIMIT + 1);
    localparam int c_entry_w = ADDR_W + DATA_W;
    localparam logic [c_stall_w-1:0] c_stall_max = c_stall_w'(STARVE_LIMIT);

    logic [c_entry_w-1:0] w_head;
    logic [c_lvl_w-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_acc;
    grant_e               w_grant;
    rd_tag_e              r_tag;
    logic                 r_rd_pending;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [c_stall_w-1:0] r_stall_cnt;
    logic [c_stall_w-1:0] w_stall_next;
    logic                 r_starve;

    // Ready looks only at registered state so it never depends on this cycle's pop.
    assign bus.dr_ready = bus.dr_we ? !w_full : !r_rd_pending;
    assign w_push       = bus.dr_valid && bus.dr_ready && bus.dr_we;
    assign w_rd_acc     = bus.dr_valid && bus.dr_ready && !bus.dr_we;

    fb_wq_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({bus.dr_addr, bus.dr_wdata}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Strict-priority grant; held idle during reset so the SRAM is never enabled.
    always_comb begin
        w_grant = GNT_IDLE;
        if (!rst_n) begin
            w_grant = GNT_IDLE;
        end else if (bus.scan_req) begin
            w_grant = GNT_SCAN;
        end else if (!w_empty) begin
            w_grant = GNT_WR;
        end else if (r_rd_pending) begin
            w_grant = GNT_RD;
        end
    end

    assign w_pop = (w_grant == GNT_WR);

    // SRAM port steering from the grant.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.scan_addr;
        bus.mem_wdata = w_head[DATA_W-1:0];
        unique case (w_grant)
            GNT_SCAN: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.scan_addr;
            end
            GNT_WR: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = w_head[c_entry_w-1:DATA_W];
            end
            GNT_RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = r_rd_addr;
            end
            default: begin
            end
        endcase
    end

    // Remember who issued this cycle's read so the returning data is routed back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag <= TAG_NONE;
        end else begin
            case (w_grant)
                GNT_SCAN: r_tag <= TAG_SCAN;
                GNT_RD:   r_tag <= TAG_DRAW;
                default:  r_tag <= TAG_NONE;
            endcase
        end
    end

    // Single outstanding draw read: latch on accept, clear once it reaches the SRAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
        end else if (w_rd_acc) begin
            r_rd_pending <= 1'b1;
            r_rd_addr    <= bus.dr_addr;
        end else if (w_grant == GNT_RD) begin
            r_rd_pending <= 1'b0;
        end
    end

    // Count consecutive cycles scanout blocks a non-empty write queue.
    always_comb begin
        w_stall_next = r_stall_cnt;
        if (w_empty || w_pop) begin
            w_stall_next = '0;
        end else if (bus.scan_req && (r_stall_cnt != c_stall_max)) begin
            w_stall_next = r_stall_cnt + c_stall_w'(1);
        end
    end

    // Stall counter and its saturation flag, kept in step with each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_starve    <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_next;
            r_starve    <= (w_stall_next == c_stall_max);
        end
    end

    assign bus.scan_rvalid = (r_tag == TAG_SCAN);
    assign bus.scan_rdata  = bus.mem_rdata;
    assign bus.dr_rvalid   = (r_tag == TAG_DRAW);
    assign bus.dr_rdata    = bus.mem_rdata;
    assign bus.wq_level    = w_count;
    assign bus.busy        = !w_empty || r_rd_pending;
    assign bus.starve      = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Self-checking bench for fb_arbiter with a behavioural
//               framebuffer that returns the address low byte until written.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;
    import fb_pkg::*;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 8;
    localparam int WQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 64;

    typedef struct {
        int sreq, saddr, dv, dwe, daddr, dwd;
        int e_en, e_we, e_addr, e_wd, e_rdy, e_lvl, e_busy, e_srv, e_sd, e_drv, e_dd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vt [8];
    int   drain_lvl [6];
    int   n;

    fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)) bus ();

    fb_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .WQ_DEPTH     (WQ_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer model: unwritten locations read back as their address low byte.
    logic [DATA_W-1:0] fbmem   [1 << ADDR_W];
    bit                fbvalid [1 << ADDR_W];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                fbmem[bus.mem_addr]   <= bus.mem_wdata;
                fbvalid[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= fbvalid[bus.mem_addr] ? fbmem[bus.mem_addr] : bus.mem_addr[7:0];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sreq, input int saddr, input int dv, input int dwe,
                         input int daddr, input int dwd);
        bus.scan_req  = 1'(sreq);
        bus.scan_addr = ADDR_W'(saddr);
        bus.dr_valid  = 1'(dv);
        bus.dr_we     = 1'(dwe);
        bus.dr_addr   = ADDR_W'(daddr);
        bus.dr_wdata  = DATA_W'(dwd);
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        // write then read of one location with scanout interleaved
        vt[0] = '{1, 'h10, 1, 1, 'h123, 'hA5,  1, 0, 'h10,  0,    1, 0, 0,  0, 0,    0, 0};
        vt[1] = '{1, 'h11, 1, 0, 'h123, 0,     1, 0, 'h11,  0,    1, 1, 1,  1, 'h10, 0, 0};
        vt[2] = '{0, 0,    0, 0, 0,     0,     1, 1, 'h123, 'hA5, 0, 1, 1,  1, 'h11, 0, 0};
        vt[3] = '{1, 'h12, 0, 0, 0,     0,     1, 0, 'h12,  0,    0, 0, 1,  0, 0,    0, 0};
        vt[4] = '{0, 0,    0, 0, 0,     0,     1, 0, 'h123, 0,    0, 0, 1,  1, 'h12, 0, 0};
        vt[5] = '{1, 'h13, 0, 0, 0,     0,     1, 0, 'h13,  0,    1, 0, 0,  0, 0,    1, 'hA5};
        vt[6] = '{0, 0,    0, 0, 0,     0,     0, 0, 0,     0,    1, 0, 0,  1, 'h13, 0, 0};
        vt[7] = '{0, 0,    0, 0, 0,     0,     0, 0, 0,     0,    1, 0, 0,  0, 0,    0, 0};
        drain_lvl = '{4, 3, 3, 2, 1, 0};

        // ---- reset with requests held ----
        rst_n = 1'b0;
        drive(1, 'h5, 1, 1, 'h7, 'h33);
        for (int k = 0; k < 3; k++) begin
            to_mid();
            chk("reset_mem_en", 32'(bus.mem_en), 0);
            to_next();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        to_mid();
        chk("post_reset_wq_level", 32'(bus.wq_level), 0);
        chk("post_reset_busy", 32'(bus.busy), 0);
        chk("post_reset_scan_rvalid", 32'(bus.scan_rvalid), 0);
        chk("post_reset_starve", 32'(bus.starve), 0);
        to_next();

        // ---- back-to-back scanout reads ----
        for (int k = 0; k < 12; k++) begin
            if (k < 10) drive(1, k, 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0);
            to_mid();
            if (k < 10) begin
                chk("scan_mem_en", 32'(bus.mem_en), 1);
                chk("scan_mem_addr", 32'(bus.mem_addr), k);
            end
            chk("scan_rvalid", 32'(bus.scan_rvalid), (k >= 1 && k <= 10) ? 1 : 0);
            if (k >= 1 && k <= 10) chk("scan_rdata", 32'(bus.scan_rdata), k - 1);
            to_next();
        end

        // ---- table: write, read-after-write ordering, overlapping returns ----
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].sreq, vt[i].saddr, vt[i].dv, vt[i].dwe, vt[i].daddr, vt[i].dwd);
            to_mid();
            chk($sformatf("tbl%0d_mem_en", i), 32'(bus.mem_en), vt[i].e_en);
            if (vt[i].e_en != 0) begin
                chk($sformatf("tbl%0d_mem_we", i), 32'(bus.mem_we), vt[i].e_we);
                chk($sformatf("tbl%0d_mem_addr", i), 32'(bus.mem_addr), vt[i].e_addr);
                if (vt[i].e_we != 0)
                    chk($sformatf("tbl%0d_mem_wdata", i), 32'(bus.mem_wdata), vt[i].e_wd);
            end
            chk($sformatf("tbl%0d_dr_ready", i), 32'(bus.dr_ready), vt[i].e_rdy);
            chk($sformatf("tbl%0d_wq_level", i), 32'(bus.wq_level), vt[i].e_lvl);
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), vt[i].e_busy);
            chk($sformatf("tbl%0d_scan_rvalid", i), 32'(bus.scan_rvalid), vt[i].e_srv);
            if (vt[i].e_srv != 0)
                chk($sformatf("tbl%0d_scan_rdata", i), 32'(bus.scan_rdata), vt[i].e_sd);
            chk($sformatf("tbl%0d_dr_rvalid", i), 32'(bus.dr_rvalid), vt[i].e_drv);
            if (vt[i].e_drv != 0)
                chk($sformatf("tbl%0d_dr_rdata", i), 32'(bus.dr_rdata), vt[i].e_dd);
            to_next();
        end

        // ---- scanout hogs the port: queue fills, starvation flag rises ----
        for (int k = 0; k < 101; k++) begin
            n = (k < 4) ? k : 4;
            drive(1, 'h200, 1, 1, 'h300 + n, 'h10 + n);
            to_mid();
            if (k < 4) chk("fill_dr_ready", 32'(bus.dr_ready), 1);
            if (k == 4) begin
                chk("full_dr_ready", 32'(bus.dr_ready), 0);
                chk("full_wq_level", 32'(bus.wq_level), 4);
            end
            if (k == 60) chk("starve_early", 32'(bus.starve), 0);
            if (k == 70 || k == 100) chk("starve_set", 32'(bus.starve), 1);
            to_next();
        end

        // ---- scanout drops: queue drains in order, 5th write slips in ----
        for (int d = 0; d < 6; d++) begin
            if (d < 2) drive(0, 0, 1, 1, 'h304, 'h14);
            else       drive(0, 0, 0, 0, 0, 0);
            to_mid();
            chk("drain_wq_level", 32'(bus.wq_level), drain_lvl[d]);
            if (d < 5) begin
                chk("drain_mem_we", 32'(bus.mem_we), 1);
                chk("drain_mem_addr", 32'(bus.mem_addr), 'h300 + d);
                chk("drain_mem_wdata", 32'(bus.mem_wdata), 'h10 + d);
            end else begin
                chk("drain_idle_mem_en", 32'(bus.mem_en), 0);
                chk("drain_idle_busy", 32'(bus.busy), 0);
            end
            if (d == 0) begin
                chk("full_pop_dr_ready", 32'(bus.dr_ready), 0);
                chk("drain_starve_held", 32'(bus.starve), 1);
            end
            if (d == 1) begin
                chk("after_pop_dr_ready", 32'(bus.dr_ready), 1);
                chk("drain_starve_clear", 32'(bus.starve), 0);
            end
            to_next();
        end

        // ---- pointer wrap with simultaneous push/pop at level 2 ----
        for (int c = 0; c < 12; c++) begin
            if (c < 2)      drive(1, 'h200, 1, 1, 'h400 + c, c + 1);
            else if (c < 9) drive(0, 0, 1, 1, 'h400 + c, c + 1);
            else            drive(0, 0, 0, 0, 0, 0);
            to_mid();
            chk("wrap_wq_level", 32'(bus.wq_level), (c == 0) ? 0 : (c == 1) ? 1 : (c <= 9) ? 2 : (c == 10) ? 1 : 0);
            if (c >= 2 && c <= 10) begin
                chk("wrap_mem_we", 32'(bus.mem_we), 1);
                chk("wrap_mem_addr", 32'(bus.mem_addr), 'h400 + c - 2);
                chk("wrap_mem_wdata", 32'(bus.mem_wdata), c - 1);
            end
            to_next();
        end
        for (int j = 0; j < 9; j++) begin
            chk("wrap_fb_content", 32'(fbmem[ADDR_W'('h400 + j)]), j + 1);
        end

        // ---- reset pulse discards queued writes and the pending read ----
        for (int r = 0; r < 4; r++) begin
            if (r < 3) drive(1, 'h200, 1, 1, 'h500 + r, 'h50 + r);
            else       drive(1, 'h200, 1, 0, 'h500, 0);
            to_mid();
            chk("pre_rst_dr_ready", 32'(bus.dr_ready), 1);
            to_next();
        end
        drive(1, 'h200, 0, 0, 0, 0);
        to_mid();
        chk("pre_rst_wq_level", 32'(bus.wq_level), 3);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        to_next();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        to_mid();
        chk("pulse_rst_mem_en", 32'(bus.mem_en), 0);
        to_next();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            to_mid();
            chk("after_rst_mem_we", 32'(bus.mem_we), 0);
            chk("after_rst_dr_rvalid", 32'(bus.dr_rvalid), 0);
            chk("after_rst_wq_level", 32'(bus.wq_level), 0);
            to_next();
        end
        to_mid();
        chk("after_rst_busy", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
